mips_inst_encoder: RTL and testbench



---
 rtl/mips_inst_encoder.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder
// Turns symbolic instruction requests into encoded 32-bit MIPS words, each
// tagged with its load address, and queues them for the instruction-memory
// writer. LI is expanded to LUI/ORI; out-of-range immediates are rejected
// with a one-cycle err pulse.
// Build option: define MIPS64_EN to add DADDU, DADDIU, DSLL and DSRL
// (kinds 32..35). Without it those kinds are rejected like any other
// unknown kind.
//
// state  | meaning
// IDLE   | accepting requests while the FIFO has room
// SECOND | holding the ORI half of a split LI until the FIFO has room

module mips_inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [5:0] K_NOP   = 6'd0;
    localparam logic [5:0] K_ADD   = 6'd1;
    localparam logic [5:0] K_ADDU  = 6'd2;
    localparam logic [5:0] K_SUB   = 6'd3;
    localparam logic [5:0] K_AND   = 6'd4;
    localparam logic [5:0] K_OR    = 6'd5;
    localparam logic [5:0] K_XOR   = 6'd6;
    localparam logic [5:0] K_NOR   = 6'd7;
    localparam logic [5:0] K_SLT   = 6'd8;
    localparam logic [5:0] K_SLL   = 6'd9;
    localparam logic [5:0] K_SRL   = 6'd10;
    localparam logic [5:0] K_JR    = 6'd11;
    localparam logic [5:0] K_ADDI  = 6'd12;
    localparam logic [5:0] K_ADDIU = 6'd13;
    localparam logic [5:0] K_ANDI  = 6'd14;
    localparam logic [5:0] K_ORI   = 6'd15;
    localparam logic [5:0] K_XORI  = 6'd16;
    localparam logic [5:0] K_LUI   = 6'd17;
    localparam logic [5:0] K_LW    = 6'd18;
    localparam logic [5:0] K_LBU   = 6'd19;
    localparam logic [5:0] K_SW    = 6'd20;
    localparam logic [5:0] K_SB    = 6'd21;
    localparam logic [5:0] K_BEQ   = 6'd22;
    localparam logic [5:0] K_BNE   = 6'd23;
    localparam logic [5:0] K_J     = 6'd24;
    localparam logic [5:0] K_MFC0  = 6'd25;
    localparam logic [5:0] K_MTC0  = 6'd26;
    localparam logic [5:0] K_ERET  = 6'd27;
    localparam logic [5:0] K_LI    = 6'd28;
    localparam logic [5:0] K_MOVE  = 6'd29;
`ifdef MIPS64_EN
    localparam logic [5:0] K_DADDU  = 6'd32;
    localparam logic [5:0] K_DADDIU = 6'd33;
    localparam logic [5:0] K_DSLL   = 6'd34;
    localparam logic [5:0] K_DSRL   = 6'd35;
`endif

    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {6'h00, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

    state_t        state;
    logic [31:0]   pending_word;
    logic [31:0]   next_addr;

    logic [31:0]   mem_word [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   last_word;
    logic [31:0]   last_addr;

    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   push_word;

    logic          enc_legal;
    logic          enc_split;
    logic [31:0]   enc_word0;
    logic [31:0]   enc_word1;
    logic          sext_ok;
    logic          zext_ok;
    logic [15:0]   imm_hi;
    logic [15:0]   imm_lo;

    assign imm_hi  = req_imm[31:16];
    assign imm_lo  = req_imm[15:0];
    assign sext_ok = (req_imm[31:15] == '0) || (req_imm[31:15] == '1);
    assign zext_ok = (imm_hi == '0);

    // Encode the presented request and decide whether it is legal / split
    always_comb begin
        enc_legal = 1'b1;
        enc_split = 1'b0;
        enc_word0 = 32'h0000_0000;
        enc_word1 = 32'h0000_0000;
        case (req_kind)
            K_NOP:   enc_word0 = 32'h0000_0000;
            K_ADD:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h20);
            K_ADDU:  enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h21);
            K_SUB:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h22);
            K_AND:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h24);
            K_OR:    enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h25);
            K_XOR:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h26);
            K_NOR:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h27);
            K_SLT:   enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h2A);
            K_SLL: begin
                enc_legal = (req_imm[31:5] == '0);
                enc_word0 = r_word(5'd0, req_rt, req_rd, req_imm[4:0], 6'h00);
            end
            K_SRL: begin
                enc_legal = (req_imm[31:5] == '0);
                enc_word0 = r_word(5'd0, req_rt, req_rd, req_imm[4:0], 6'h02);
            end
            K_JR:    enc_word0 = r_word(req_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            K_ADDI: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_ADDI, req_rs, req_rt, imm_lo);
            end
            K_ADDIU: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_ADDIU, req_rs, req_rt, imm_lo);
            end
            K_ANDI: begin
                enc_legal = zext_ok;
                enc_word0 = i_word(OP_ANDI, req_rs, req_rt, imm_lo);
            end
            K_ORI: begin
                enc_legal = zext_ok;
                enc_word0 = i_word(OP_ORI, req_rs, req_rt, imm_lo);
            end
            K_XORI: begin
                enc_legal = zext_ok;
                enc_word0 = i_word(OP_XORI, req_rs, req_rt, imm_lo);
            end
            K_LUI: begin
                enc_legal = zext_ok;
                enc_word0 = i_word(OP_LUI, 5'd0, req_rt, imm_lo);
            end
            K_LW: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_LW, req_rs, req_rt, imm_lo);
            end
            K_LBU: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_LBU, req_rs, req_rt, imm_lo);
            end
            K_SW: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_SW, req_rs, req_rt, imm_lo);
            end
            K_SB: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_SB, req_rs, req_rt, imm_lo);
            end
            K_BEQ: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_BEQ, req_rs, req_rt, imm_lo);
            end
            K_BNE: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(OP_BNE, req_rs, req_rt, imm_lo);
            end
            K_J: begin
                enc_legal = (req_imm[31:26] == '0);
                enc_word0 = {OP_J, req_imm[25:0]};
            end
            K_MFC0:  enc_word0 = {OP_COP0, 5'd0, req_rt, req_rd, 11'd0};
            K_MTC0:  enc_word0 = {OP_COP0, 5'd4, req_rt, req_rd, 11'd0};
            K_ERET:  enc_word0 = ERET_WORD;
            K_LI: begin
                // A zero half lets LI collapse to a single instruction
                if (imm_hi == '0) begin
                    enc_word0 = i_word(OP_ORI, 5'd0, req_rt, imm_lo);
                end else if (imm_lo == '0) begin
                    enc_word0 = i_word(OP_LUI, 5'd0, req_rt, imm_hi);
                end else begin
                    enc_split = 1'b1;
                    enc_word0 = i_word(OP_LUI, 5'd0, req_rt, imm_hi);
                    enc_word1 = i_word(OP_ORI, req_rt, req_rt, imm_lo);
                end
            end
            K_MOVE:  enc_word0 = r_word(req_rs, 5'd0, req_rd, 5'd0, 6'h21);
`ifdef MIPS64_EN
            K_DADDU: enc_word0 = r_word(req_rs, req_rt, req_rd, 5'd0, 6'h2D);
            K_DADDIU: begin
                enc_legal = sext_ok;
                enc_word0 = i_word(6'h19, req_rs, req_rt, imm_lo);
            end
            K_DSLL: begin
                // Shifts of 32..63 use the "+32" funct with shamt = imm - 32
                enc_legal = (req_imm[31:6] == '0);
                enc_word0 = r_word(5'd0, req_rt, req_rd, req_imm[4:0],
                                   req_imm[5] ? 6'h3C : 6'h38);
            end
            K_DSRL: begin
                enc_legal = (req_imm[31:6] == '0);
                enc_word0 = r_word(5'd0, req_rt, req_rd, req_imm[4:0],
                                   req_imm[5] ? 6'h3E : 6'h3A);
            end
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    assign full       = (count == CW'(DEPTH));
    assign req_ready  = (state == ST_IDLE) && !full;
    assign accept     = req_valid && req_ready;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? mem_word[rd_ptr] : last_word;
    assign inst_addr  = inst_valid ? mem_addr[rd_ptr] : last_addr;

    // Select what, if anything, enters the FIFO this cycle
    always_comb begin
        push      = 1'b0;
        push_word = enc_word0;
        if (state == ST_SECOND) begin
            push      = !full;
            push_word = pending_word;
        end else if (accept && enc_legal) begin
            push = 1'b1;
        end
    end

    // Sequencer: LI split handling, error pulse and address counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pending_word <= 32'h0000_0000;
            next_addr    <= BASE_ADDR;
            err          <= 1'b0;
        end else begin
            err <= accept && !enc_legal;
            if (push) begin
                next_addr <= next_addr + 32'd4;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && enc_legal && enc_split) begin
                        pending_word <= enc_word1;
                        state        <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (!full) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO; the last popped entry is kept for display while empty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_word[i] <= 32'h0000_0000;
                mem_addr[i] <= 32'h0000_0000;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_word <= 32'h0000_0000;
            last_addr <= 32'h0000_0000;
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= push_word;
                mem_addr[wr_ptr] <= next_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_word <= mem_word[rd_ptr];
                last_addr <= mem_addr[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Scoreboard bench for mips_inst_encoder: each accepted request pushes its
// expected words/addresses; the output monitor pops and compares on every
// FIFO handshake.

module tb_mips_inst_encoder;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_kind;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        err;

    exp_t        exp_q[$];
    logic [31:0] exp_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    mips_inst_encoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm    (req_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output side: compare every handshake against the scoreboard head
    always @(negedge clock) begin
        if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '{word: 32'hxxxx_xxxx, addr: 32'hxxxx_xxxx};
            check("inst", inst, e.word);
            check("inst_addr", inst_addr, e.addr);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        exp_addr = 32'h0000_0000;
        @(posedge clock); #2;
        reset_n = 1'b1;
        @(posedge clock); #2;
    endtask

    // n = number of words expected (0 means the request must be rejected)
    task automatic send(input logic [5:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] imm, input int n,
                        input logic [31:0] w0, input logic [31:0] w1);
        int  waited = 0;
        bit  acc = 0;
        bit  timed_out = 0;
        req_kind  = kind;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_imm   = imm;
        req_valid = 1'b1;
        while (!acc && !timed_out) begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                acc = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    check("ready_timeout", {31'd0, req_ready}, 32'd1);
                    timed_out = 1;
                end
            end
        end
        if (acc) begin
            if (n >= 1) begin
                exp_q.push_back('{word: w0, addr: exp_addr});
                exp_addr += 32'd4;
            end
            if (n == 2) begin
                exp_q.push_back('{word: w1, addr: exp_addr});
                exp_addr += 32'd4;
            end
        end
        @(posedge clock); #2;
        req_valid = 1'b0;
        if (acc) begin
            @(negedge clock);
            check("err", {31'd0, err}, (n == 0) ? 32'd1 : 32'd0);
            if (n == 2) check("ready_in_second", {31'd0, req_ready}, 32'd0);
            if (n == 0) begin
                @(negedge clock);
                check("err_pulse_end", {31'd0, err}, 32'd0);
            end
            @(posedge clock); #2;
        end
    endtask

    task automatic wait_drain();
        int budget = 500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        check("drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b1;
        req_valid  = 1'b0;
        req_kind   = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_rd     = '0;
        req_imm    = '0;
        inst_ready = 1'b1;
        exp_addr   = '0;
        #1;
        do_reset();

        send(6'd2, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h0022_1821, 32'd0);
        wait_drain();

        do_reset();
        send(6'd28, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 2, 32'h3C08_1234, 32'h3508_5678);
        send(6'd28, 5'd0, 5'd8, 5'd0, 32'h0000_5678, 1, 32'h3408_5678, 32'd0);
        send(6'd28, 5'd0, 5'd8, 5'd0, 32'hABCD_0000, 1, 32'h3C08_ABCD, 32'd0);
        send(6'd12, 5'd0, 5'd1, 5'd0, 32'h0000_8000, 0, 32'd0, 32'd0);
        send(6'd40, 5'd0, 5'd0, 5'd0, 32'd0,         0, 32'd0, 32'd0);
        send(6'd15, 5'd2, 5'd1, 5'd0, 32'h0000_FFFF, 1, 32'h3441_FFFF, 32'd0);
        send(6'd12, 5'd0, 5'd1, 5'd0, 32'hFFFF_8000, 1, 32'h2001_8000, 32'd0);
        send(6'd9,  5'd0, 5'd2, 5'd3, 32'd31,        1, 32'h0002_1FC0, 32'd0);
        send(6'd9,  5'd0, 5'd2, 5'd3, 32'd32,        0, 32'd0, 32'd0);
        send(6'd24, 5'd0, 5'd0, 5'd0, 32'h03FF_FFFF, 1, 32'h0BFF_FFFF, 32'd0);
        send(6'd24, 5'd0, 5'd0, 5'd0, 32'h0400_0000, 0, 32'd0, 32'd0);
        send(6'd17, 5'd0, 5'd1, 5'd0, 32'h0001_0000, 0, 32'd0, 32'd0);
        send(6'd11, 5'd31, 5'd0, 5'd0, 32'd0,        1, 32'h03E0_0008, 32'd0);
        send(6'd27, 5'd0, 5'd0, 5'd0, 32'd0,         1, 32'h4200_0018, 32'd0);
        send(6'd25, 5'd0, 5'd2, 5'd12, 32'd0,        1, 32'h4002_6000, 32'd0);
        send(6'd26, 5'd0, 5'd2, 5'd12, 32'd0,        1, 32'h4082_6000, 32'd0);
        send(6'd29, 5'd5, 5'd0, 5'd4, 32'd0,         1, 32'h00A0_2021, 32'd0);
        send(6'd20, 5'd29, 5'd3, 5'd0, 32'hFFFF_FFFC, 1, 32'hAFA3_FFFC, 32'd0);
        send(6'd7,  5'd2, 5'd3, 5'd1, 32'd0,         1, 32'h0043_0827, 32'd0);
        wait_drain();

        // Full FIFO back-pressure, then drain in order
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'd0, 32'd0);
        @(negedge clock);
        check("full_ready", {31'd0, req_ready}, 32'd0);
        check("full_valid", {31'd0, inst_valid}, 32'd1);
        check("full_head_addr", inst_addr, 32'h0000_0000);
        @(posedge clock); #2;
        fork
            send(6'd2, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h0022_1821, 32'd0);
            begin
                repeat (3) @(posedge clock);
                #2;
                inst_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while holding the ORI half of a split LI
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'd0, 32'd0);
        send(6'd28, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 2, 32'h3C08_1234, 32'h3508_5678);
        @(negedge clock);
        check("second_hold_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #2;
        do_reset();
        inst_ready = 1'b1;
        send(6'd2, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h0022_1821, 32'd0);
        wait_drain();

`ifdef MIPS64_EN
        send(6'd34, 5'd0, 5'd4, 5'd2, 32'd40, 1, 32'h0004_123C, 32'd0);
`else
        send(6'd34, 5'd0, 5'd4, 5'd2, 32'd40, 0, 32'd0, 32'd0);
`endif
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
